// File: rtl/segment_display_pkg.sv
// Shared types and helpers for the segment display arbiter.
// Ownership FSM states and a width helper used by the slice.
package segment_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_OPEN
  } state_e;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/segment_display_arbiter_rr_pick.sv
// Round-robin search: first asserted req after owner, wrapping.
// The owner's own position is checked last.
module rr_pick
  import segment_display_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    owner,
  output logic [OW-1:0]    winner,
  output logic             valid
);

  int idx;

  // Walk from farthest to nearest so the nearest hit is written last
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(owner) + i) % N_REQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/segment_display_arbiter.sv
// Shares one 7-segment driver among N_REQ requesters with a
// minimum dwell time and round-robin hand-over.
module segment_display_arbiter
  import segment_display_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int WIDTH_NIBBLES = 6,
  parameter int DWELL_CYCLES  = 390625
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [N_REQ-1:0]                   req,
  input  logic [N_REQ*WIDTH_NIBBLES*4-1:0]   req_data,
  input  logic [N_REQ*WIDTH_NIBBLES-1:0]     req_digit_enable,
  input  logic [N_REQ*WIDTH_NIBBLES-1:0]     req_dp_enable,
  output logic [N_REQ-1:0]                   grant,
  output logic [clog2_min1(N_REQ)-1:0]       owner,
  output logic [WIDTH_NIBBLES*4-1:0]         data,
  output logic [WIDTH_NIBBLES-1:0]           digit_enable,
  output logic [WIDTH_NIBBLES-1:0]           decimal_point_enable
);

  localparam int OW = clog2_min1(N_REQ);
  localparam int CW = clog2_min1(DWELL_CYCLES);
  localparam int DW = WIDTH_NIBBLES * 4;
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] masked;
  logic [OW-1:0]    win;
  logic             win_vld;
  logic             owner_req;
  logic             take;

  // The owner never competes against itself for a switch
  assign masked    = req & ~grant_q;
  assign owner_req = req[owner_q];

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req    (masked),
    .owner  (owner_q),
    .winner (win),
    .valid  (win_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= OW'(N_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      ST_IDLE: take = win_vld;
      ST_HOLD, ST_OPEN: begin
        if (!owner_req) begin
          take = win_vld;
          if (!win_vld) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (state_q == ST_OPEN) begin
          take = win_vld;
        end else if (cnt_q == '0) begin
          state_d = ST_OPEN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_HOLD;
      owner_d = win;
      grant_d = ONE << win;
      cnt_d   = RELOAD;
    end
  end

  // Live copy of the current owner's slices; blank when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data                 <= '0;
      digit_enable         <= '0;
      decimal_point_enable <= '0;
    end else if (|grant_q) begin
      data <= req_data[int'(owner_q)*DW +: DW];
      digit_enable <=
        req_digit_enable[int'(owner_q)*WIDTH_NIBBLES +: WIDTH_NIBBLES];
      decimal_point_enable <=
        req_dp_enable[int'(owner_q)*WIDTH_NIBBLES +: WIDTH_NIBBLES];
    end else begin
      data                 <= '0;
      digit_enable         <= '0;
      decimal_point_enable <= '0;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_segment_display_arbiter.sv
// Directed bench for segment_display_arbiter, dwell of 4 cycles.
// Table of per-cycle vectors plus hand-written corner sequences.
module tb_segment_display_arbiter;

  localparam int N  = 4;
  localparam int WN = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N*WN*4-1:0] req_data;
  logic [N*WN-1:0]   req_digit_enable;
  logic [N*WN-1:0]   req_dp_enable;
  logic [N-1:0]  grant;
  logic [1:0]    owner;
  logic [WN*4-1:0] data;
  logic [WN-1:0] digit_enable;
  logic [WN-1:0] decimal_point_enable;

  int checks = 0;
  int errors = 0;

  segment_display_arbiter #(
    .N_REQ         (N),
    .WIDTH_NIBBLES (WN),
    .DWELL_CYCLES  (4)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req                  (req),
    .req_data             (req_data),
    .req_digit_enable     (req_digit_enable),
    .req_dp_enable        (req_dp_enable),
    .grant                (grant),
    .owner                (owner),
    .data                 (data),
    .digit_enable         (digit_enable),
    .decimal_point_enable (decimal_point_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [5:0] den;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // digit masks 01,02,04,08; dp masks 20,10,08,04; data i+1 repeated
    for (int i = 0; i < N; i++) begin
      req_data[i*24 +: 24]     = {6{4'(i + 1)}};
      req_digit_enable[i*6 +: 6] = 6'h01 << i;
      req_dp_enable[i*6 +: 6]    = 6'h20 >> i;
    end

    tbl[0]  = '{4'b0101, 4'b0001, 2'd0, 6'h00};
    tbl[1]  = '{4'b0101, 4'b0001, 2'd0, 6'h01};
    tbl[2]  = '{4'b0101, 4'b0001, 2'd0, 6'h01};
    tbl[3]  = '{4'b0101, 4'b0001, 2'd0, 6'h01};
    tbl[4]  = '{4'b0101, 4'b0001, 2'd0, 6'h01};
    tbl[5]  = '{4'b0101, 4'b0100, 2'd2, 6'h01};
    tbl[6]  = '{4'b0101, 4'b0100, 2'd2, 6'h04};
    tbl[7]  = '{4'b0101, 4'b0100, 2'd2, 6'h04};
    tbl[8]  = '{4'b0101, 4'b0100, 2'd2, 6'h04};
    tbl[9]  = '{4'b0101, 4'b0100, 2'd2, 6'h04};
    tbl[10] = '{4'b0101, 4'b0001, 2'd0, 6'h04};
    tbl[11] = '{4'b0000, 4'b0000, 2'd0, 6'h01};
    tbl[12] = '{4'b0000, 4'b0000, 2'd0, 6'h00};
    tbl[13] = '{4'b0001, 4'b0001, 2'd0, 6'h00};
    tbl[14] = '{4'b0011, 4'b0001, 2'd0, 6'h01};
    tbl[15] = '{4'b0011, 4'b0001, 2'd0, 6'h01};
    tbl[16] = '{4'b0011, 4'b0001, 2'd0, 6'h01};
    tbl[17] = '{4'b0011, 4'b0001, 2'd0, 6'h01};
    tbl[18] = '{4'b0011, 4'b0010, 2'd1, 6'h01};
    tbl[19] = '{4'b0011, 4'b0010, 2'd1, 6'h02};
    tbl[20] = '{4'b1000, 4'b1000, 2'd3, 6'h02};
    tbl[21] = '{4'b1011, 4'b1000, 2'd3, 6'h08};
    tbl[22] = '{4'b0011, 4'b0001, 2'd0, 6'h08};
    tbl[23] = '{4'b0011, 4'b0001, 2'd0, 6'h01};

    reset_n = 1'b0;
    req     = '0;
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_den", 32'(digit_enable), 32'h0);
    reset_n = 1'b1;

    for (int r = 0; r < 24; r++) begin
      req = tbl[r].req;
      step();
      chk($sformatf("grant[%0d]", r), 32'(grant), 32'(tbl[r].grant));
      chk($sformatf("owner[%0d]", r), 32'(owner), 32'(tbl[r].owner));
      chk($sformatf("den[%0d]", r), 32'(digit_enable), 32'(tbl[r].den));
      chk($sformatf("onehot[%0d]", r), 32'($onehot0(grant)), 32'd1);
    end

    // owner 0 in HOLD: registered slices follow its live inputs
    chk("data_own0", 32'(data), 32'h111111);
    chk("dp_own0", 32'(decimal_point_enable), 32'h20);
    req_data[23:0] = 24'habcdef;
    step();
    chk("data_live", 32'(data), 32'habcdef);
    chk("grant_live", 32'(grant), 32'b0001);

    // asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_owner", 32'(owner), 32'd3);
    chk("arst_data", 32'(data), 32'h0);
    chk("arst_den", 32'(digit_enable), 32'h0);
    chk("arst_dp", 32'(decimal_point_enable), 32'h0);
    step();
    reset_n = 1'b1;
    req = 4'b0100;
    step();
    chk("restart_grant", 32'(grant), 32'b0100);
    chk("restart_owner", 32'(owner), 32'd2);
    chk("restart_data0", 32'(data), 32'h0);
    step();
    chk("restart_data", 32'(data), 32'h333333);
    chk("restart_den", 32'(digit_enable), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
